// File: rtl/mc_controller_hs.sv
// Multicycle RV32I control unit with req/ready memory handshake, bounded wait timeout and sticky fault.
// Optional retired-instruction counter enabled by defining MC_INSTRET_EN.
module mc_controller_hs #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             AdrSrc,
    output logic             PCupdate,
    output logic             Branch,
    output logic             IRwrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       AluOp,
    output logic [2:0]       ImmSrc,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXER, S_EXEI,
        S_ALUWB, S_BR, S_JAL, S_JALR, S_JALWB, S_LUI, S_FAULT
    } state_t;

    state_t     state, state_n;
    logic [7:0] wait_cnt;
    logic       wait_expired;
    logic       in_wait;

    // Zero is consumed by the datapath's branch logic; func7/func3[0] only matter to the ALU decoder.
    logic unused_inputs;
    assign unused_inputs = ^{func7, Zero, func3[0]};

    assign wait_expired = !mem_ready && (wait_cnt == WAIT_LAST);
    assign in_wait      = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:  if (mem_ready) state_n = S_DECODE;
                      else if (wait_expired) state_n = S_FAULT;
            S_DECODE: begin
                case (Opcode)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_R:              state_n = S_EXER;
                    OP_I:              state_n = S_EXEI;
                    OP_BR:             state_n = (func3[2:1] == 2'b00) ? S_BR : S_FAULT;
                    OP_JAL:            state_n = S_JAL;
                    OP_JALR:           state_n = S_JALR;
                    OP_LUI:            state_n = S_LUI;
                    default:           state_n = S_FAULT;
                endcase
            end
            S_MEMADR: state_n = (Opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
                      else if (wait_expired) state_n = S_FAULT;
            S_MEMWR:  if (mem_ready) state_n = S_FETCH;
                      else if (wait_expired) state_n = S_FAULT;
            S_MEMWB, S_ALUWB, S_BR, S_JALWB, S_LUI: state_n = S_FETCH;
            S_EXER, S_EXEI, S_JAL: state_n = S_ALUWB;
            S_JALR:   state_n = S_JALWB;
            S_FAULT:  state_n = S_FAULT;
            default:  state_n = S_FAULT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_n;
            if (state_n != state || mem_ready)
                wait_cnt <= '0;
            else if (in_wait)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

`ifdef MC_INSTRET_EN
    // Every state that falls back into FETCH is the last step of a completed instruction.
    logic             retire;
    logic [CNT_W-1:0] instret_q;
    assign retire = (state != S_FETCH) && (state_n == S_FETCH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instret_q <= '0;
        else if (retire)
            instret_q <= instret_q + CNT_W'(1);
    end
    assign instret = instret_q;
`else
    assign instret = '0;
`endif

    // Outputs are held low while reset is asserted so an in-flight write strobe cannot escape.
    always_comb begin
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        PCupdate  = 1'b0;
        Branch    = 1'b0;
        IRwrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        AluSrcA   = 2'b00;
        AluSrcB   = 2'b00;
        AluOp     = 2'b00;
        ImmSrc    = 3'b000;
        fault     = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    AluSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRwrite   = mem_ready;
                    PCupdate  = mem_ready;
                end
                S_DECODE: begin
                    AluSrcA = 2'b01;
                    AluSrcB = 2'b01;
                    ImmSrc  = (Opcode == OP_JAL) ? 3'b011 : 3'b010;
                end
                S_MEMADR: begin
                    AluSrcA = 2'b10;
                    AluSrcB = 2'b01;
                    ImmSrc  = (Opcode == OP_STORE) ? 3'b001 : 3'b000;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = mem_ready;
                end
                S_EXER: begin
                    AluSrcA = 2'b10;
                    AluOp   = 2'b10;
                end
                S_EXEI: begin
                    AluSrcA = 2'b10;
                    AluSrcB = 2'b01;
                    AluOp   = 2'b10;
                end
                S_ALUWB: RegWrite = 1'b1;
                S_BR: begin
                    AluSrcA = 2'b10;
                    AluOp   = 2'b01;
                    Branch  = 1'b1;
                end
                S_JAL: begin
                    AluSrcA  = 2'b01;
                    AluSrcB  = 2'b10;
                    ImmSrc   = 3'b011;
                    PCupdate = 1'b1;
                end
                S_JALR: begin
                    AluSrcA   = 2'b10;
                    AluSrcB   = 2'b01;
                    PCupdate  = 1'b1;
                    ResultSrc = 2'b10;
                end
                S_JALWB: begin
                    AluSrcA   = 2'b01;
                    AluSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    RegWrite  = 1'b1;
                end
                S_LUI: begin
                    ImmSrc    = 3'b100;
                    AluSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    RegWrite  = 1'b1;
                end
                S_FAULT: fault = 1'b1;
                default: fault = 1'b1;
            endcase
        end
    end

endmodule
